// File: rtl/uart_cmd_ctrl.sv
// Command-frame sequencer between the UART byte receiver and the SDRAM front end.
// Parses header/command/payload frames, feeds the write FIFO and issues SDRAM triggers.
module uart_cmd_ctrl #(
    parameter logic [7:0]  HDR_BYTE = 8'h55,
    parameter logic [7:0]  CMD_WR   = 8'hAA,
    parameter logic [7:0]  CMD_RD   = 8'h5A,
    parameter int unsigned WR_LEN   = 4,
    parameter int unsigned TIMEOUT  = 52080
) (
    input  logic       s_clk,
    input  logic       s_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    input  logic       sdram_busy,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_wr_data,
    output logic       wfifo_clr,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        ISSUE
    } state_t;

    localparam logic [16:0] TO_LAST  = 17'(TIMEOUT - 1);
    localparam logic [7:0]  LEN_LAST = 8'(WR_LEN - 1);

    state_t      state, state_nx;
    logic [7:0]  byte_cnt, byte_cnt_nx;
    logic [16:0] to_cnt, to_cnt_nx;
    logic        pend_wr, pend_wr_nx;
    logic        to_expired;

    logic        wr_en_nx;
    logic [7:0]  wr_data_nx;
    logic        clr_nx;
    logic        wr_trig_nx;
    logic        rd_trig_nx;
    logic        err_nx;

    assign to_expired = (to_cnt == TO_LAST);

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        to_cnt_nx   = to_cnt;
        pend_wr_nx  = pend_wr;
        wr_en_nx    = 1'b0;
        wr_data_nx  = wfifo_wr_data;
        clr_nx      = 1'b0;
        wr_trig_nx  = 1'b0;
        rd_trig_nx  = 1'b0;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                to_cnt_nx = '0;
                if (rx_flag && rx_data == HDR_BYTE) begin
                    state_nx = CMD;
                end
            end

            CMD: begin
                if (rx_flag) begin
                    to_cnt_nx = '0;
                    if (rx_data == CMD_WR) begin
                        state_nx    = DATA;
                        byte_cnt_nx = '0;
                    end else if (rx_data == CMD_RD) begin
                        state_nx   = ISSUE;
                        pend_wr_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end
                end else if (to_expired) begin
                    state_nx  = IDLE;
                    to_cnt_nx = '0;
                    err_nx    = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + 17'd1;
                end
            end

            DATA: begin
                // A byte landing on the expiry cycle still counts as payload.
                if (rx_flag) begin
                    to_cnt_nx   = '0;
                    wr_en_nx    = 1'b1;
                    wr_data_nx  = rx_data;
                    byte_cnt_nx = byte_cnt + 8'd1;
                    if (byte_cnt == LEN_LAST) begin
                        state_nx   = ISSUE;
                        pend_wr_nx = 1'b1;
                    end
                end else if (to_expired) begin
                    state_nx  = IDLE;
                    to_cnt_nx = '0;
                    err_nx    = 1'b1;
                    clr_nx    = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + 17'd1;
                end
            end

            ISSUE: begin
                to_cnt_nx = '0;
                if (!sdram_busy) begin
                    state_nx   = IDLE;
                    wr_trig_nx = pend_wr;
                    rd_trig_nx = !pend_wr;
                end else if (rx_flag) begin
                    err_nx = 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            to_cnt        <= '0;
            pend_wr       <= 1'b0;
            wfifo_wr_en   <= 1'b0;
            wfifo_wr_data <= '0;
            wfifo_clr     <= 1'b0;
            wr_trig       <= 1'b0;
            rd_trig       <= 1'b0;
            frame_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            byte_cnt      <= byte_cnt_nx;
            to_cnt        <= to_cnt_nx;
            pend_wr       <= pend_wr_nx;
            wfifo_wr_en   <= wr_en_nx;
            wfifo_wr_data <= wr_data_nx;
            wfifo_clr     <= clr_nx;
            wr_trig       <= wr_trig_nx;
            rd_trig       <= rd_trig_nx;
            frame_err     <= err_nx;
            busy          <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a frame-level parser model predicts output
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] HDR = 8'h55;
    localparam logic [7:0] CWR = 8'hAA;
    localparam logic [7:0] CRD = 8'h5A;
    localparam int         LEN = 4;
    localparam int         TO  = 600;

    // event vectors: {wr_en, clr, wr_trig, rd_trig, frame_err}
    localparam logic [4:0] EV_PUSH   = 5'b10000;
    localparam logic [4:0] EV_WR     = 5'b00100;
    localparam logic [4:0] EV_RD     = 5'b00010;
    localparam logic [4:0] EV_ERR    = 5'b00001;
    localparam logic [4:0] EV_ERRCLR = 5'b01001;

    logic       s_clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_flag = 1'b0;
    logic       sdram_busy = 1'b0;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       wfifo_clr;
    logic       wr_trig;
    logic       rd_trig;
    logic       frame_err;
    logic       busy;

    uart_cmd_ctrl #(
        .HDR_BYTE(HDR),
        .CMD_WR  (CWR),
        .CMD_RD  (CRD),
        .WR_LEN  (LEN),
        .TIMEOUT (TO)
    ) dut (
        .s_clk        (s_clk),
        .s_rst_n      (s_rst_n),
        .rx_data      (rx_data),
        .rx_flag      (rx_flag),
        .sdram_busy   (sdram_busy),
        .wfifo_wr_en  (wfifo_wr_en),
        .wfifo_wr_data(wfifo_wr_data),
        .wfifo_clr    (wfifo_clr),
        .wr_trig      (wr_trig),
        .rd_trig      (rd_trig),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    typedef struct {
        int         at;
        logic [4:0] v;
        logic [7:0] d;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] frame[$];
    int         last_cyc = 0;
    bit         issuing = 1'b0;
    int         trig_cyc = 0;
    logic [4:0] pend_v = '0;
    bit         to_pending = 1'b0;
    int         to_cyc = 0;
    bit         to_clr = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic push_exp(input int at, input logic [4:0] v, input logic [7:0] d);
        exp_t e;
        e.at = at;
        e.v  = v;
        e.d  = d;
        expq.push_back(e);
    endtask

    task automatic start_issue(input logic [4:0] v, input int n);
        issuing = 1'b1;
        if (!sdram_busy) begin
            trig_cyc = n + 1;
            push_exp(n + 1, v, 8'h00);
        end else begin
            trig_cyc = -1;
            pend_v   = v;
        end
    endtask

    // Frame-level reference: frame[] holds header, command and payload seen so far.
    task automatic model_byte(input logic [7:0] b, input int n);
        if (frame.size() > 0 && n > last_cyc + TO) frame.delete();
        if (issuing && trig_cyc >= 0 && n > trig_cyc) issuing = 1'b0;
        if (issuing) begin
            push_exp(n, EV_ERR, 8'h00);
            return;
        end
        if (frame.size() == 0) begin
            if (b == HDR) frame.push_back(b);
        end else if (frame.size() == 1) begin
            if (b == CWR) frame.push_back(b);
            else begin
                frame.delete();
                if (b == CRD) start_issue(EV_RD, n);
                else push_exp(n, EV_ERR, 8'h00);
            end
        end else begin
            push_exp(n, EV_PUSH, b);
            frame.push_back(b);
            if (frame.size() == 2 + LEN) begin
                frame.delete();
                start_issue(EV_WR, n);
            end
        end
        last_cyc   = n;
        to_pending = (frame.size() > 0);
        to_cyc     = n + TO;
        to_clr     = (frame.size() >= 2);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge s_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap - 1);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge s_clk);
        #1;
        rx_flag = 1'b0;
        model_byte(b, cyc);
    endtask

    task automatic release_busy();
        @(posedge s_clk);
        #1;
        sdram_busy = 1'b0;
        if (issuing && trig_cyc < 0) begin
            trig_cyc = cyc + 1;
            push_exp(cyc + 1, pend_v, 8'h00);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        frame.delete();
        issuing    = 1'b0;
        to_pending = 1'b0;
        last_data  = 8'h00;
    endtask

    logic [4:0] obs_v;
    logic [4:0] exp_v;
    logic [7:0] exp_d;
    bit         have;

    always @(negedge s_clk) begin
        if (s_rst_n) begin
            have  = 1'b0;
            exp_v = '0;
            exp_d = 8'h00;
            while (expq.size() > 0 && expq[0].at < cyc) begin
                check("missing_event", 32'(0), 32'(expq[0].v));
                void'(expq.pop_front());
            end
            if (to_pending && to_cyc < cyc) begin
                check("missing_timeout", 32'(0), 32'(EV_ERR));
                to_pending = 1'b0;
            end
            if (to_pending && to_cyc == cyc) begin
                exp_v      = to_clr ? EV_ERRCLR : EV_ERR;
                have       = 1'b1;
                to_pending = 1'b0;
            end else if (expq.size() > 0 && expq[0].at == cyc) begin
                exp_v = expq[0].v;
                exp_d = expq[0].d;
                have  = 1'b1;
                void'(expq.pop_front());
            end
            obs_v = {wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, frame_err};
            if (have || obs_v != 5'b0) begin
                check("event_pulses", 32'(obs_v), 32'(exp_v));
                if (exp_v[4]) begin
                    check("push_data", 32'(wfifo_wr_data), 32'(exp_d));
                    last_data = exp_d;
                end
            end else if (cyc % 8 == 0) begin
                check("wr_data_hold", 32'(wfifo_wr_data), 32'(last_data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         g;
        int         r;

        #1;
        check("reset_outputs", 32'({wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, frame_err, busy}), 32'(0));
        check("reset_wr_data", 32'(wfifo_wr_data), 32'(0));
        idle(3);
        s_rst_n = 1'b1;
        idle(3);

        // 1: write frame, bytes spaced 100 cycles
        send_byte(HDR, 100);
        check("busy_after_hdr", 32'(busy), 32'(1));
        send_byte(CWR, 100);
        send_byte(8'h11, 100);
        send_byte(8'h22, 100);
        send_byte(8'h33, 100);
        send_byte(8'h44, 100);
        check("busy_before_trig", 32'(busy), 32'(1));
        idle(1);
        check("busy_after_wr_trig", 32'(busy), 32'(0));
        idle(10);

        // 2: read frame held off by sdram_busy; bytes meanwhile are dropped
        sdram_busy = 1'b1;
        send_byte(HDR, 5);
        send_byte(CRD, 10);
        send_byte(HDR, 10);
        send_byte(8'h11, 10);
        idle(20);
        check("busy_while_held", 32'(busy), 32'(1));
        release_busy();
        idle(1);
        check("busy_after_rd_trig", 32'(busy), 32'(0));
        idle(10);

        // 3: bad command, then a normal read
        send_byte(HDR, 5);
        send_byte(8'h3C, 5);
        idle(1);
        check("busy_after_bad_cmd", 32'(busy), 32'(0));
        send_byte(HDR, 5);
        send_byte(CRD, 5);
        idle(10);

        // 4: timeout mid-payload, then a byte landing exactly on the expiry cycle
        send_byte(HDR, 5);
        send_byte(CWR, 5);
        send_byte(8'h11, 5);
        send_byte(8'h22, 5);
        idle(TO + 20);
        check("busy_after_timeout", 32'(busy), 32'(0));
        send_byte(HDR, 5);
        send_byte(CWR, 5);
        send_byte(8'h11, 5);
        send_byte(8'h22, 5);
        send_byte(8'h33, TO);
        check("busy_boundary_byte", 32'(busy), 32'(1));
        send_byte(8'h44, 5);
        idle(10);

        // 4b: timeout in CMD gives frame_err without clr
        send_byte(HDR, 5);
        idle(TO + 10);

        // 5: stray bytes in IDLE
        send_byte(8'h00, 5);
        check("busy_stray_00", 32'(busy), 32'(0));
        send_byte(CWR, 5);
        check("busy_stray_aa", 32'(busy), 32'(0));
        send_byte(CRD, 5);
        check("busy_stray_5a", 32'(busy), 32'(0));
        idle(10);

        // 6: reset mid-frame, then a clean write frame
        send_byte(HDR, 5);
        send_byte(CWR, 5);
        send_byte(8'h11, 5);
        idle(1);
        s_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_outputs", 32'({wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, frame_err, busy}), 32'(0));
        check("rst_wr_data", 32'(wfifo_wr_data), 32'(0));
        idle(3);
        s_rst_n = 1'b1;
        idle(2);
        send_byte(HDR, 5);
        send_byte(CWR, 5);
        send_byte(8'hA1, 5);
        send_byte(8'hB2, 5);
        send_byte(8'hC3, 5);
        send_byte(8'hD4, 5);
        idle(10);

        // random traffic biased toward frame bytes, with occasional near-timeout gaps
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30) b = HDR;
            else if (r < 50) b = CWR;
            else if (r < 65) b = CRD;
            else b = 8'($urandom);
            if ($urandom_range(0, 99) < 4) g = int'($urandom_range(TO - 2, TO + 2));
            else g = int'($urandom_range(2, 30));
            send_byte(b, g);
        end

        idle(TO + 20);
        check("queue_drained", 32'(expq.size()), 32'(0));
        check("timeout_drained", 32'(to_pending), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
